// File: rtl/up_state_ctrl.sv
// up_state_ctrl: uP BOOT/RUN/PAUSING/PAUSED controller with a debounced pause button and debug toggle.
module up_state_ctrl #(
  parameter int DB_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_bootDone,
  input  logic       i_coreHLT,
  input  logic       i_coreNowPaused,
  input  logic       i_pauseBtn,
  input  logic       i_extReq,
  output logic       o_smIsBooted,
  output logic       o_smStartPause,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {BOOT, RUN, PAUSING, PAUSED} state_t;
  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, db_q, db_d, prev_q, eq, hit, evt;
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    eq      = sync2_q == db_q;
    hit     = cnt_q == 16'(DB_CYCLES - 1);
    cnt_d   = (eq || hit) ? 16'd0 : cnt_q + 16'd1;
    db_d    = (!eq && hit) ? sync2_q : db_q;
    evt     = (db_q & ~prev_q) | i_extReq;
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = i_bootDone ? RUN : BOOT;
      RUN:     state_d = (evt || i_coreHLT) ? PAUSING : RUN;
      PAUSING: state_d = i_coreNowPaused ? PAUSED : PAUSING;
      PAUSED:  state_d = evt ? RUN : PAUSED;
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= BOOT;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= i_pauseBtn;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      prev_q  <= db_q;
      cnt_q   <= cnt_d;
    end
  end
  // The core's pause flop tracks o_smStartPause, so it must stay high through PAUSED.
  assign o_smIsBooted   = state_q != BOOT;
  assign o_smStartPause = state_q[1];
  assign o_state        = state_q;
endmodule

// File: tb/tb_up_state_ctrl.sv
// tb_up_state_ctrl: table-driven and scoreboarded checks of up_state_ctrl with DB_CYCLES=4.
module tb_up_state_ctrl;
  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, PAUSING = 2'd2, PAUSED = 2'd3;
  typedef struct {
    logic b, h, np, btn, e;
    int n;
    logic [1:0] st;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic boot_done = 1'b0, hlt = 1'b0, now_paused = 1'b0, btn = 1'b0, ext = 1'b0;
  logic is_booted, start_pause;
  logic [1:0] state;
  logic [1:0] exp_q[$];
  vec_t tbl[$];
  int compared = 0, mismatched = 0;

  up_state_ctrl #(.DB_CYCLES(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_bootDone(boot_done), .i_coreHLT(hlt),
    .i_coreNowPaused(now_paused), .i_pauseBtn(btn), .i_extReq(ext),
    .o_smIsBooted(is_booted), .o_smStartPause(start_pause), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got booted/pause/state=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] decode(input logic [1:0] st);
    return {st != BOOT, st == PAUSING || st == PAUSED, st};
  endfunction

  task automatic step(input string name, input logic b, h, np, bt, e, input logic [1:0] st);
    @(negedge clk);
    boot_done = b; hlt = h; now_paused = np; btn = bt; ext = e;
    exp_q.push_back(st);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) cmp({name, "_empty"}, {is_booted, start_pause, state}, 4'bxxxx);
    else cmp(name, {is_booted, start_pause, state}, decode(exp_q.pop_front()));
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++)
        step($sformatf("%s%0d", name, i), tbl[i].b, tbl[i].h, tbl[i].np, tbl[i].btn, tbl[i].e, tbl[i].st);
    tbl.delete();
  endtask

  initial begin
    #12;
    cmp("reset", {is_booted, start_pause, state}, 4'b0000);
    @(negedge clk) rstn = 1'b1;
    // b h np btn e n st
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, BOOT});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, BOOT});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, BOOT});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, RUN});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, RUN});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, PAUSING});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, PAUSING});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, PAUSING});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, PAUSED});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, PAUSED});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, RUN});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, RUN});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, PAUSING});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, PAUSING});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, PAUSED});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, RUN});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, PAUSING});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, PAUSED});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, RUN});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, PAUSING});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, PAUSED});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, RUN});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, RUN});
    run_tbl("tbl");
    // Debounce: a 3-cycle bounce is rejected, the final rise pauses at edge DB_CYCLES+3.
    for (int k = 0; k < 3; k++) step("bounce_hi", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
    for (int k = 0; k < 2; k++) step("bounce_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    for (int k = 1; k <= 6; k++) step($sformatf("press_wait%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RUN);
    step("press_edge7", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PAUSING);
    for (int k = 0; k < 3; k++) step("press_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PAUSING);
    step("press_paused", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, PAUSED);
    for (int k = 0; k < 10; k++) step("held_btn", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, PAUSED);
    for (int k = 0; k < 12; k++) step("release", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, PAUSED);
    // HLT auto-pause coinciding with a debug request, then a long pause hold.
    step("resume", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN);
    step("hlt_ext", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, PAUSING);
    step("hlt_np", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, PAUSED);
    for (int k = 0; k < 50; k++) step("hold50", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, PAUSED);
    // Asynchronous reset between edges while paused.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    cmp("async_rst", {is_booted, start_pause, state}, 4'b0000);
    @(negedge clk) rstn = 1'b1;
    step("after_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BOOT);
    step("reboot", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    if (exp_q.size() != 0) cmp("queue_drain", 4'(exp_q.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end
endmodule
